uart_sample_receiver: RTL and testbench

- Host-to-FPGA counterpart of the sample UART stream; receives 8N1 frames of the form "C","H",'0'+ch,MSB,LSB at BAUD.
- Decodes each frame and writes the 16-bit signed sample into a per-channel shadow register.
- Presents all four channels to the DSP core / output_cal path, updated coherently on each rising edge of sample_clk.
- Lets a host drive the DAC outputs (test waveforms, remote CV) over the same serial link.

---
 rtl/uart_sample_pkg.sv | 24 ++
 rtl/uart_rx.sv | 89 ++++++++
 rtl/uart_sample_receiver.sv | 129 ++++++++++++
 tb/tb_uart_sample_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_sample_pkg.sv
// Shared definitions for the sample UART link: ASCII framing constants,
// parser states and the 5-byte frame layout "C","H",'0'+ch,MSB,LSB.
package uart_sample_pkg;

  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_0 = 8'h30;

  localparam int FRAME_BYTES = 5;
  localparam int NUM_CH      = 4;

  typedef enum logic [2:0] {IDLE, GOT_C, GOT_H, MSB, LSB} parse_state_e;

  typedef struct packed {
    logic [1:0]         ch;
    logic signed [15:0] sample;
  } sample_frame_t;

  // Channel byte is '0'..'3', i.e. 0x30..0x33.
  function automatic logic is_ch_byte(input logic [7:0] b);
    return b[7:2] == CH_0[7:2];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 2-FF synchroniser plus 8N1 byte receiver; sampling at bit centres,
// rearms right after the stop-bit sample so back-to-back bytes work.
module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          rx_m_q, rx_s_q, rx_p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_p_q && !rx_s_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_M1) begin
        // Line back high at mid start bit: a glitch, drop silently.
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        sh_d  = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL_M1) begin
        valid_d = rx_s_q;
        err_d   = !rx_s_q;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      rx_p_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = sh_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/uart_sample_receiver.sv
// Decodes "CH<ch><msb><lsb>" frames into per-channel shadow registers and
// transfers all shadows to the outputs together on each sample_clk rise.
module uart_sample_receiver
  import uart_sample_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 4160
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               sample_clk,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3,
  output logic               frame_valid,
  output logic [1:0]         frame_ch,
  output logic               frame_err
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CLKS);

  logic       byte_valid, byte_err;
  logic [7:0] byte_data;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_err(byte_err)
  );

  parse_state_e                 st_q, st_d;
  logic [1:0]                   ch_q, ch_d, fch_q, fch_d;
  logic [7:0]                   msb_q, msb_d;
  logic [NUM_CH-1:0][15:0]      shadow_q, shadow_d, out_q, out_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         fv_q, fv_d, fe_q, fe_d, last_sc_q;

  always_comb begin
    st_d     = st_q;
    ch_d     = ch_q;
    msb_d    = msb_q;
    shadow_d = shadow_q;
    fch_d    = fch_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    tmo_d    = (tmo_q == TMO) ? tmo_q : tmo_q + 1'b1;
    if (byte_err) begin
      st_d = IDLE;
      fe_d = 1'b1;
    end else if (byte_valid) begin
      tmo_d = '0;
      unique case (st_q)
        IDLE:  if (byte_data == CH_C) st_d = GOT_C;
        GOT_C: begin
          if (byte_data == CH_H)      st_d = GOT_H;
          else if (byte_data == CH_C) st_d = GOT_C;
          else begin st_d = IDLE; fe_d = 1'b1; end
        end
        GOT_H: begin
          if (is_ch_byte(byte_data)) begin
            st_d = MSB;
            ch_d = byte_data[1:0];
          end else begin
            // A stray 'C' may be the start of the next frame.
            st_d = (byte_data == CH_C) ? GOT_C : IDLE;
            fe_d = 1'b1;
          end
        end
        MSB: begin
          msb_d = byte_data;
          st_d  = LSB;
        end
        LSB: begin
          shadow_d[ch_q] = {msb_q, byte_data};
          fv_d  = 1'b1;
          fch_d = ch_q;
          st_d  = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end else if (st_q != IDLE && tmo_q == TMO) begin
      st_d = IDLE;
      fe_d = 1'b1;
    end
  end

  // Outputs copy the registered shadow, so a same-cycle write lands next edge.
  always_comb begin
    out_d = out_q;
    if (sample_clk && !last_sc_q) out_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      ch_q      <= '0;
      msb_q     <= '0;
      shadow_q  <= '0;
      out_q     <= '0;
      tmo_q     <= '0;
      fch_q     <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      last_sc_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      ch_q      <= ch_d;
      msb_q     <= msb_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      tmo_q     <= tmo_d;
      fch_q     <= fch_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
      last_sc_q <= sample_clk;
    end
  end

  assign sample_out0 = out_q[0];
  assign sample_out1 = out_q[1];
  assign sample_out2 = out_q[2];
  assign sample_out3 = out_q[3];
  assign frame_valid = fv_q;
  assign frame_ch    = fch_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_uart_sample_receiver.sv
// Directed bench: serial frames driven bit by bit, outputs checked after
// sample_clk edges, frame_valid/frame_err pulses counted by a monitor.
module tb_uart_sample_receiver;
  localparam int BIT = 104;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx = 1'b1;
  logic               sample_clk = 1'b0;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic               frame_valid, frame_err;
  logic [1:0]         frame_ch;

  int passed = 0;
  int total  = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int fv_base, fe_base;

  uart_sample_receiver dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .sample_clk(sample_clk),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3),
    .frame_valid(frame_valid), .frame_ch(frame_ch), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [15:0] v);
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h30 + 8'(ch));
    send_byte(v[15:8]);
    send_byte(v[7:0]);
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_sample();
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk);
    sample_clk = 1'b0;
  endtask

  task automatic mark();
    repeat (2) @(negedge clk);
    fv_base = fv_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_out0", sample_out0, 16'h0);
    chk("rst_out3", sample_out3, 16'h0);
    chk("rst_fv", {15'b0, frame_valid}, 16'h0);
    chk("rst_fe", {15'b0, frame_err}, 16'h0);
    chk("rst_ch", {14'b0, frame_ch}, 16'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic frame to channel 2
    mark();
    send_frame(2'd2, 16'h1234);
    chk("f2_fv", 16'(fv_cnt - fv_base), 16'd1);
    chk("f2_ch", {14'b0, frame_ch}, 16'd2);
    chk("f2_pre", sample_out2, 16'h0);
    pulse_sample();
    chk("f2_out2", sample_out2, 16'h1234);
    chk("f2_out0", sample_out0, 16'h0);
    chk("f2_out1", sample_out1, 16'h0);
    chk("f2_out3", sample_out3, 16'h0);

    // Resync on doubled 'C'
    mark();
    send_byte(8'h43);
    send_frame(2'd1, 16'h8000);
    chk("ccc_fv", 16'(fv_cnt - fv_base), 16'd1);
    chk("ccc_fe", 16'(fe_cnt - fe_base), 16'd0);
    pulse_sample();
    chk("ccc_out1", sample_out1, 16'h8000);

    // Bad channel byte, then good frame on channel 0
    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h34);
    repeat (10) @(negedge clk);
    chk("badch_fe", 16'(fe_cnt - fe_base), 16'd1);
    chk("badch_fv", 16'(fv_cnt - fv_base), 16'd0);
    send_frame(2'd0, 16'hFFFF);
    pulse_sample();
    chk("badch_out0", sample_out0, 16'hFFFF);
    chk("badch_out2", sample_out2, 16'h1234);

    // Stop-bit error on MSB byte
    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h33);
    send_byte(8'h55, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    chk("stop_fe", 16'(fe_cnt - fe_base), 16'd1);
    chk("stop_fv", 16'(fv_cnt - fv_base), 16'd0);
    pulse_sample();
    chk("stop_out3", sample_out3, 16'h0);
    send_frame(2'd3, 16'h0A0B);
    pulse_sample();
    chk("stop_next", sample_out3, 16'h0A0B);

    // Timeout inside a frame, no stale MSB afterwards
    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h30);
    send_byte(8'hAB);
    repeat (5000) @(negedge clk);
    chk("tmo_fe", 16'(fe_cnt - fe_base), 16'd1);
    chk("tmo_fv", 16'(fv_cnt - fv_base), 16'd0);
    send_frame(2'd0, 16'h0102);
    pulse_sample();
    chk("tmo_out0", sample_out0, 16'h0102);

    // 30-clock glitch while in GOT_C must not inject a byte
    mark();
    send_byte(8'h43);
    @(negedge clk) rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    send_byte(8'h48);
    send_byte(8'h31);
    send_byte(8'h7F);
    send_byte(8'hFE);
    repeat (10) @(negedge clk);
    chk("gl_fe", 16'(fe_cnt - fe_base), 16'd0);
    chk("gl_fv", 16'(fv_cnt - fv_base), 16'd1);
    pulse_sample();
    chk("gl_out1", sample_out1, 16'h7FFE);

    // Reset in the middle of the LSB byte
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h32);
    send_byte(8'h11);
    @(negedge clk) rx = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_out0", sample_out0, 16'h0);
    chk("mrst_out1", sample_out1, 16'h0);
    chk("mrst_out2", sample_out2, 16'h0);
    chk("mrst_out3", sample_out3, 16'h0);
    chk("mrst_ch", {14'b0, frame_ch}, 16'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    mark();
    send_frame(2'd3, 16'h2233);
    chk("post_fv", 16'(fv_cnt - fv_base), 16'd1);
    pulse_sample();
    chk("post_out3", sample_out3, 16'h2233);
    chk("post_out2", sample_out2, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
